// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding AR/R read at a time, static next-PC
// prediction, one-entry output buffer to decode, redirect flush/restart.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_predict_o,
    output logic        fetch_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, OUT} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred;
        logic        err;
    } fetch_buf_t;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] kill_pc;
    logic        kill;
    fetch_buf_t  obuf;

    logic        rd_fault;
    logic [31:0] rd_inst;
    logic [31:0] imm_j;
    logic [31:0] imm_b;
    logic [31:0] rd_pred;

    // Faulting reads deliver a zero word, which also forces the pc+4 prediction.
    always_comb begin
        rd_fault = (rresp != 2'b00);
        rd_inst  = rd_fault ? 32'h0 : rdata;
        imm_j    = {{12{rd_inst[31]}}, rd_inst[19:12], rd_inst[20], rd_inst[30:21], 1'b0};
        imm_b    = {{20{rd_inst[31]}}, rd_inst[7], rd_inst[30:25], rd_inst[11:8], 1'b0};
        rd_pred  = fetch_pc + 32'd4;
        if (rd_inst[6:0] == OPC_JAL)
            rd_pred = fetch_pc + imm_j;
        else if (rd_inst[6:0] == OPC_BRANCH && rd_inst[31])
            rd_pred = fetch_pc + imm_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            kill      <= 1'b0;
            kill_pc   <= '0;
            obuf      <= '0;
            fetch_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect_valid)
                        fetch_pc <= redirect_pc;
                    state <= REQ;
                end
                REQ: begin
                    // The request stays up; a redirect only marks its response as dead.
                    if (redirect_valid) begin
                        kill    <= 1'b1;
                        kill_pc <= redirect_pc;
                    end
                    if (arready)
                        state <= RESP;
                end
                RESP: begin
                    if (rvalid) begin
                        kill <= 1'b0;
                        if (redirect_valid) begin
                            fetch_pc <= redirect_pc;
                            state    <= REQ;
                        end else if (kill) begin
                            fetch_pc <= kill_pc;
                            state    <= REQ;
                        end else begin
                            obuf  <= '{inst: rd_inst, pc: fetch_pc, pred: rd_pred, err: rd_fault};
                            state <= OUT;
                        end
                    end else if (redirect_valid) begin
                        kill    <= 1'b1;
                        kill_pc <= redirect_pc;
                    end
                end
                OUT: begin
                    if (out_ready)
                        fetch_cnt <= fetch_cnt + 32'd1;
                    if (redirect_valid) begin
                        fetch_pc <= redirect_pc;
                        state    <= REQ;
                    end else if (out_ready) begin
                        fetch_pc <= obuf.pred;
                        state    <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign araddr       = fetch_pc;
    assign arvalid      = (state == REQ);
    assign rready       = (state == RESP);
    assign out_valid    = (state == OUT);
    assign inst_o       = obuf.inst;
    assign pc_o         = obuf.pc;
    assign pc_predict_o = obuf.pred;
    assign fetch_err    = obuf.err;

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch stage directly upstream of the decode stage. It issues 32-bit instruction reads on an AXI4-Lite-style read channel (AR/R only). It statically predicts the next PC and hands {inst, pc, pc_predict} to decode over a valid/ready handshake. On a redirect from the execute/writeback side (mispredict, jalr, trap, mret, fence.i), it discards any in-flight or buffered work and restarts from the supplied target.

## Interface
- RESET_PC, 32'h3000_0000, first fetch address after reset

- clk  in  1  clock
- rst  in  1  reset rst, asynchronous, active-high
- araddr  out  32  fetch address
- arvalid  out  1  read-address valid
- arready  in  1  read-address ready
- rdata  in  32  read data (instruction)
- rresp  in  2  read response; non-zero = access fault
- rvalid  in  1  read-data valid
- rready  out  1  read-data ready
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode accepts (decode's in_ready)
- inst_o  out  32  fetched instruction
- pc_o  out  32  address of inst_o
- pc_predict_o  out  32  predicted next PC
- fetch_err  out  1  inst_o came from a faulting read (inst_o = 0)
- redirect_valid  in  1  flush and restart (control hazard)
- redirect_pc  in  32  restart target
- fetch_cnt  out  32  instructions delivered to decode, wraps mod 2^32

## Operation
- FSM states: IDLE, REQ, RESP, OUT. Registers: fetch_pc, kill, kill_pc, output buffer.
- IDLE: the reset state. Moves to REQ on the next cycle.
- REQ: arvalid=1, araddr=fetch_pc. On arready, move to RESP.
  - araddr and arvalid stay stable until arready. The request is never withdrawn.
- RESP: rready=1. On rvalid:
  - kill=0: latch inst_o=rdata (0 if rresp!=0), pc_o=fetch_pc, pc_predict_o, and fetch_err=(rresp!=0). Move to OUT.
  - kill=1: discard the data, set fetch_pc=kill_pc, clear kill, and move to REQ.
- OUT: out_valid=1. On out_ready, set fetch_pc=pc_predict_o, increment fetch_cnt, and move to REQ.
- Prediction is computed from rdata at latch time. All sums are 32-bit and wrap modulo 2^32.
  - opcode 1101111 (jal): pc + immJ.
  - opcode 1100011 (branch) with inst[31]=1 (backward): pc + immB.
  - Everything else (including jalr, forward branches, and faults): pc + 4.
- Redirect handling, when redirect_valid=1:
  - IDLE: fetch_pc=redirect_pc.
  - REQ or RESP (transaction outstanding): set kill=1 and kill_pc=redirect_pc. The next response is discarded.
  - OUT: drop the buffer, set fetch_pc=redirect_pc, and move to REQ. fetch_cnt increments only if out_ready was also high that cycle.
  - A redirect during REQ with arready high in the same cycle still sets kill. The response is discarded in RESP.
  - A redirect during RESP with rvalid in the same cycle discards the data. The FSM moves straight to REQ with redirect_pc, and kill stays 0.
  - Repeated redirects while kill=1: the latest redirect_pc wins. Only one response is discarded.
- At most one read is outstanding at any time.

## Timing
- Values during and immediately after reset:
  - state=IDLE, arvalid=0, rready=0, out_valid=0.
  - araddr=fetch_pc=RESET_PC.
  - inst_o=pc_o=pc_predict_o=0, fetch_err=0, fetch_cnt=0, kill=0.
- First arvalid: the second rising edge after rst deasserts, i.e. IDLE lasts one cycle.
- arvalid, rready, and out_valid are decoded from the state register. They have no combinational path from any input.
- Minimum latency with a zero-wait bus (arready and rvalid high on first sight):
  - 3 cycles per instruction (REQ, RESP, OUT) when out_ready=1.
  - The next REQ starts the cycle after the OUT handshake.
- out_valid falls in the cycle after a redirect taken in OUT.
  - In the redirect cycle itself out_valid may still be 1. Decode flushes on its own control_hazard.
- out_valid=1 holds inst_o, pc_o, pc_predict_o, and fetch_err stable until out_ready or a redirect.
- Asserting rst mid-transaction returns everything to reset values immediately. The bus slave is reset by the same rst.

## Test plan
- Reset, then a 0-wait bus returning 32'h00000013 for every address, out_ready=1 -> araddr sequence 3000_0000, 3000_0004, 3000_0008, with a 3-cycle spacing. pc_predict_o = pc+4. fetch_cnt reaches 3.
- Fetch of jal x0,-8 (32'hFF9FF06F) at 3000_0010 -> pc_predict_o=3000_0008, next araddr=3000_0008. beq backward (inst[31]=1) with offset -4 -> predict pc-4. Forward beq -> pc+4.
- arready held low 5 cycles, with redirect_valid pulsed (redirect_pc=3000_0100) in cycle 2 -> araddr stays stable until arready. The response is discarded with out_valid never rising. The next araddr is 3000_0100.
- out_ready=0 for 4 cycles in OUT -> outputs hold, no new arvalid, fetch_cnt unchanged. A redirect to 3000_0200 then drops out_valid next cycle, and the next araddr is 3000_0200.
- rresp=2'b10 on a fetch at 3000_0020 -> inst_o=0, fetch_err=1, pc_predict_o=3000_0024. fetch_err clears on the next good fetch.
- Two redirects (3000_0300, then 3000_0400) during one outstanding read, plus rst asserted mid-RESP in a separate run -> the next fetch is 3000_0400. After the rst run, all outputs return to reset values and fetching restarts at RESET_PC.
